// File: rtl/cnt_seq_pkg.sv
// Shared types and defaults for the cnt_seq counter sequencer.
//   state_t     : two-state run control (IDLE, RUN)
//   DEF_WIDTH   : default counter / limit width
//   DEF_PW      : default completed-period counter width
package cnt_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PW    = 8;

endpackage

// File: rtl/cnt_core.sv
// Count datapath for cnt_seq: a plain up-counter with clear and enable.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : force count to zero (wins over en)
//   en    : increment count by one
//   cnt   : current count value
module cnt_core
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cnt_seq.sv
// Counter sequencer: counts 0..limit per period in one-shot or auto-reload
// mode, pulses done at each period end and tracks completed periods.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : request a run (accepted only in IDLE and only without stop)
//   stop    : abort a run; beats start and terminal count
//   limit   : terminal count, latched on accepted start
//   mode    : 0 = one-shot, 1 = auto-reload, latched on accepted start
//   cnt     : current count
//   busy    : high while running
//   done    : one-cycle pulse per completed period
//   periods : completed periods since the last accepted start, saturating
module cnt_seq
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PW    = DEF_PW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    periods
);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] limit_q,   limit_d;
    logic             mode_q,    mode_d;
    logic [PW-1:0]    periods_q, periods_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;
    logic             clr;
    logic             en;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (&v) ? v : v + PW'(1);
    endfunction

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .cnt   (cnt)
    );

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        periods_d = periods_q;
        done_d    = 1'b0;
        // The count is held at zero everywhere except a mid-period RUN cycle.
        clr       = 1'b1;
        en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = RUN;
                    limit_d   = limit;
                    mode_d    = mode;
                    periods_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt == limit_q) begin
                    done_d    = 1'b1;
                    periods_d = sat_inc(periods_q);
                    if (!mode_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    clr = 1'b0;
                    en  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            periods_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            periods_q <= periods_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign periods = periods_q;

endmodule
